// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and defaults for the register-file write arbiter
package rf_arb_pkg;

    typedef enum logic {
        ARB_NORM  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-B-write flags (set on issue, clear on B handshake)
module rf_scoreboard
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   i_issue,
    input  logic [ADDR_W-1:0]      i_issue_addr,
    input  logic                   i_retire,
    input  logic [ADDR_W-1:0]      i_retire_addr,
    output logic [2**ADDR_W-1:0]   o_busy
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_issue)
            w_set[i_issue_addr] = 1'b1;
        if (i_retire)
            w_clr[i_retire_addr] = 1'b1;
        w_set[0] = 1'b0;
    end

    // Set has priority so a re-issue in the retiring cycle stays pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end

    assign o_busy = {r_busy[NREGS-1:1], 1'b0};

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single-write-port arbiter: pipeline writeback (A) vs multi-cycle unit (B)
// Optional scoreboard enabled by macro RF_SCOREBOARD_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   a_we,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_stall,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_data,
    output logic                   b_ready,
    input  logic                   b_issue,
    input  logic [ADDR_W-1:0]      b_issue_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic                   reg_write_sig,
    output logic [ADDR_W-1:0]      write_reg,
    output logic [DATA_W-1:0]      write_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_a_live;
    logic w_grant_a;
    logic w_grant_b;
    logic w_a_stall;
    logic w_b_ready;
    logic w_b_blocked;

    assign w_a_live = a_we && (a_addr != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ARB_NORM;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_a_stall   = 1'b0;
        w_b_ready   = 1'b0;
        w_state_nxt = ARB_NORM;
        w_cnt_nxt   = '0;

        if (r_state == ARB_FORCE && b_valid) begin
            w_grant_b = 1'b1;
            w_b_ready = 1'b1;
            w_a_stall = a_we;
        end else if (w_a_live) begin
            w_grant_a = 1'b1;
        end else if (b_valid) begin
            w_grant_b = 1'b1;
            w_b_ready = 1'b1;
        end

        w_b_blocked = b_valid && !w_b_ready;

        // Forced grant is one cycle; counter restarts on entry.
        if (w_b_blocked) begin
            if (r_state == ARB_NORM && r_cnt == CNT_LAST)
                w_state_nxt = ARB_FORCE;
            else
                w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        reg_write_sig = 1'b0;
        write_reg     = '0;
        write_data    = '0;
        if (RST_N) begin
            if (w_grant_a) begin
                reg_write_sig = 1'b1;
                write_reg     = a_addr;
                write_data    = a_data;
            end else if (w_grant_b && b_addr != '0) begin
                reg_write_sig = 1'b1;
                write_reg     = b_addr;
                write_data    = b_data;
            end
        end
    end

    assign a_stall = RST_N && w_a_stall;
    assign b_ready = RST_N && w_b_ready;

`ifdef RF_SCOREBOARD_EN
    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .i_issue       (b_issue),
        .i_issue_addr  (b_issue_addr),
        .i_retire      (b_valid && b_ready),
        .i_retire_addr (b_addr),
        .o_busy        (busy)
    );
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{b_issue, b_issue_addr};
    assign busy = '0;
`endif

endmodule
